// File: rtl/tetris_pkg.sv
// Shared piece definitions: ids, spawn-row ROM and LFSR tap mask.
package tetris_pkg;

  localparam int NUM_PIECES = 7;

  typedef enum logic [2:0] {
    P_I = 3'd0,
    P_O = 3'd1,
    P_T = 3'd2,
    P_S = 3'd3,
    P_Z = 3'd4,
    P_J = 3'd5,
    P_L = 3'd6
  } piece_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Spawn-row ROM; [0] is the top row, bit 9 the leftmost column.
  function automatic logic [1:0][9:0] spawn_rows(input piece_t p);
    logic [1:0][9:0] r;
    r = '0;
    case (p)
      P_I: begin r[0] = 10'h078; r[1] = 10'h000; end
      P_O: begin r[0] = 10'h030; r[1] = 10'h030; end
      P_T: begin r[0] = 10'h020; r[1] = 10'h070; end
      P_S: begin r[0] = 10'h030; r[1] = 10'h060; end
      P_Z: begin r[0] = 10'h060; r[1] = 10'h030; end
      P_J: begin r[0] = 10'h040; r[1] = 10'h070; end
      P_L: begin r[0] = 10'h010; r[1] = 10'h070; end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bag_randomizer.sv
// 7-bag piece chooser: free-running LFSR picks a start id, the bag mask
// skips ids already dealt in the current bag.
module bag_randomizer
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   draw,
  output piece_t piece
);

  logic [15:0]           lfsr_q, lfsr_d;
  logic [NUM_PIECES-1:0] bag_q, bag_d;
  logic [2:0]            cand;
  logic [2:0]            pick;
  logic                  found;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    cand   = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    pick   = cand;
    found  = 1'b0;
    // The bag is never full here, so some id is always free.
    for (int k = 0; k < NUM_PIECES; k++) begin
      logic [3:0] idx;
      idx = {1'b0, cand} + 4'(k);
      if (idx >= 4'(NUM_PIECES)) idx = idx - 4'(NUM_PIECES);
      if (!found && !bag_q[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    bag_d = bag_q;
    if (draw) begin
      bag_d[pick] = 1'b1;
      if (&bag_d) bag_d = '0;
    end
  end

  assign piece = piece_t'(pick);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      bag_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      bag_q  <= bag_d;
    end
  end

endmodule

// File: rtl/piece_spawner.sv
// Current/next/hold piece bookkeeping with hold-swap rules; spawn rows are
// decoded from registered ids.
module piece_spawner
  import tetris_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            Clk,
  input  logic            Reset_h,
  input  logic            spawn_req,
  input  logic            swap_req,
  output logic [1:0][9:0] new_block,
  output logic [1:0][9:0] sblock,
  output logic [2:0]      cur_id,
  output logic [2:0]      next_id,
  output logic            swap_empty,
  output logic            can_swap,
  output logic            ready
);

  localparam logic [1:0] S_INIT0 = 2'd0;
  localparam logic [1:0] S_INIT1 = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0] state_q, state_d;
  piece_t     cur_q, cur_d, next_q, next_d, hold_q, hold_d;
  logic       swap_empty_q, swap_empty_d;
  logic       can_swap_q, can_swap_d;
  logic       pending_q, pending_d;
  logic       draw;
  piece_t     drawn;

  bag_randomizer #(.LFSR_SEED(LFSR_SEED)) u_bag (
    .clk   (Clk),
    .rst   (Reset_h),
    .draw  (draw),
    .piece (drawn)
  );

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    next_d       = next_q;
    hold_d       = hold_q;
    swap_empty_d = swap_empty_q;
    can_swap_d   = can_swap_q;
    pending_d    = pending_q;
    draw         = 1'b0;
    case (state_q)
      S_INIT0: begin
        cur_d   = drawn;
        draw    = 1'b1;
        state_d = S_INIT1;
        if (spawn_req) pending_d = 1'b1;
      end
      S_INIT1: begin
        next_d  = drawn;
        draw    = 1'b1;
        state_d = S_RUN;
        if (spawn_req) pending_d = 1'b1;
      end
      S_RUN: begin
        // A spawn (live or deferred from init) always beats a swap.
        if (spawn_req || pending_q) begin
          cur_d      = next_q;
          next_d     = drawn;
          draw       = 1'b1;
          can_swap_d = 1'b1;
          pending_d  = 1'b0;
        end else if (swap_req && can_swap_q) begin
          if (swap_empty_q) begin
            hold_d       = cur_q;
            cur_d        = next_q;
            next_d       = drawn;
            draw         = 1'b1;
            swap_empty_d = 1'b0;
          end else begin
            hold_d = cur_q;
            cur_d  = hold_q;
          end
          can_swap_d = 1'b0;
        end
      end
      default: state_d = S_INIT0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state_q      <= S_INIT0;
      cur_q        <= P_I;
      next_q       <= P_I;
      hold_q       <= P_I;
      swap_empty_q <= 1'b1;
      can_swap_q   <= 1'b1;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      next_q       <= next_d;
      hold_q       <= hold_d;
      swap_empty_q <= swap_empty_d;
      can_swap_q   <= can_swap_d;
      pending_q    <= pending_d;
    end
  end

  assign new_block  = spawn_rows(cur_q);
  assign sblock     = swap_empty_q ? '0 : spawn_rows(hold_q);
  assign cur_id     = cur_q;
  assign next_id    = next_q;
  assign swap_empty = swap_empty_q;
  assign can_swap   = can_swap_q;
  assign ready      = (state_q == S_RUN);

endmodule

// File: doc/piece_spawner.md
Name: piece_spawner

Overview:
- Upstream feeder of the active-piece write stage. Supplies the two spawn rows of the current piece (new_block) and of the held piece (sblock), plus the swap_empty and can_swap status flags.
- Chooses pieces with a 7-bag randomizer driven by a free-running LFSR, keeps a one-deep next-piece preview, and implements the hold/swap rules.

Parameters:
- LFSR_SEED, 16'hACE1, non-zero reset value of the LFSR.
- NUM_PIECES, 7, number of tetromino types. Fixed; shared package constant.

Ports:
- Clk  in  1  system clock
- Reset_h  in  1  synchronous, active-high reset
- spawn_req  in  1  1-cycle pulse; the consumer wants a new active piece
- swap_req  in  1  1-cycle pulse; hold key pressed
- new_block  out  10x[1:0]  spawn rows of the current piece; [0] = top row
- sblock  out  10x[1:0]  spawn rows of the held piece; 0 when the hold is empty
- cur_id  out  3  current piece id
- next_id  out  3  preview piece id
- swap_empty  out  1  hold slot empty
- can_swap  out  1  a swap is permitted for this piece
- ready  out  1  cur/next are valid

Behaviour:
- Piece ids and spawn rows. Column c maps to bit 9-c, so bit 9 is the leftmost column. Values are given as row[0]/row[1]:
  - I=0: 078/000
  - O=1: 030/030
  - T=2: 020/070
  - S=3: 030/060
  - Z=4: 060/030
  - J=5: 040/070
  - L=6: 010/070
  - Id 7 is invalid and is never stored.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every cycle, including during init.
  - Reset loads LFSR_SEED.
- Draw (combinational, single cycle):
  - Candidate c = lfsr[2:0]; if c is 7, c becomes 0.
  - Take the first id at or after c (mod 7) whose bag bit is clear.
  - Set that bag bit. If this makes the bag full (7'h7F), clear the bag to 0 in the same cycle.
- FSM states:
  - INIT0: draw into cur, go to INIT1.
  - INIT1: draw into next, go to RUN.
  - RUN: ready=1.
- Reset (any state, any cycle):
  - State becomes INIT0; bag and pending are cleared; hold is emptied (swap_empty=1); can_swap=1.
  - cur_id and next_id become 0. new_block is therefore I (078/000).
  - sblock becomes 0; ready becomes 0.
- spawn_req in RUN: takes effect next edge.
  - cur <= next, next <= draw, can_swap <= 1.
  - new_block changes one cycle after the req.
- spawn_req in INIT0/INIT1: latched as pending and serviced on the first RUN cycle.
  - At most one pending spawn; further reqs are dropped.
- swap_req in RUN with can_swap=1:
  - If the hold is empty: hold <= cur, cur <= next, next <= draw, swap_empty <= 0.
  - Otherwise: exchange cur and hold (no draw).
  - Either case: can_swap <= 0.
- swap_req when can_swap=0, or outside RUN: ignored.
- spawn_req and swap_req in the same cycle: spawn wins; the swap is dropped.
- Outputs are registered ids decoded through a constant ROM. No combinational path from req inputs to outputs.
- Invariant checked by the bench: cur_id, next_id and hold are never 7.

Decomposition:
- tetris_pkg holds:
  - piece_t (3-bit enum I..L)
  - NUM_PIECES
  - SPAWN_ROWS ROM (piece_t to two 10-bit rows)
  - LFSR taps
- One sub-module: bag_randomizer. It contains the LFSR, the bag mask and the draw logic, with a draw strobe in and a piece_t out.
- piece_spawner contains the FSM, the cur/next/hold registers and the swap rules.

Test Plan:
- Reset, then idle 3 cycles:
  - ready=0 for exactly 2 cycles after reset release, then 1.
  - swap_empty=1, can_swap=1, sblock=0.
  - cur_id and next_id both in 0..6.
- Bag property:
  - Issue 14 spawn_req pulses, 2 cycles apart.
  - Every aligned group of 7 draws, counted from reset and including the 2 init draws, contains each id 0..6 exactly once.
  - new_block always matches the ROM for cur_id.
- First swap:
  - Record cur=A, next=B; pulse swap_req.
  - Next cycle: sblock=rows(A), cur=B, swap_empty=0, can_swap=0.
  - A second swap_req is ignored; all outputs are unchanged.
- Swap with a held piece:
  - Spawn, then swap.
  - cur and hold exchange with no draw: next_id is unchanged and can_swap returns to 0.
- Simultaneous requests:
  - spawn_req and swap_req in the same cycle: only the spawn happens, can_swap=1, hold is unchanged.
  - spawn_req during INIT0: serviced on the first RUN cycle; cur equals the init next.
- Reset mid-operation:
  - Assert Reset_h one cycle while the hold is full.
  - Next cycle: swap_empty=1, sblock=0, ready=0, state INIT0.
  - LFSR restarts from LFSR_SEED, so the draw sequence repeats the first run.
